// File: rtl/rv32_mem_pkg.sv
// Shared load/store definitions for the RV32IM memory stage: func3 codes,
// LSU state encoding and func3 legality helpers.
package rv32_mem_pkg;

    localparam logic [2:0] FUNC3_LB  = 3'b000;
    localparam logic [2:0] FUNC3_LH  = 3'b001;
    localparam logic [2:0] FUNC3_LW  = 3'b010;
    localparam logic [2:0] FUNC3_LBU = 3'b100;
    localparam logic [2:0] FUNC3_LHU = 3'b101;
    localparam logic [2:0] FUNC3_SB  = 3'b000;
    localparam logic [2:0] FUNC3_SH  = 3'b001;
    localparam logic [2:0] FUNC3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    function automatic logic load_func3_ok(input logic [2:0] f3);
        logic ok;
        case (f3)
            FUNC3_LB, FUNC3_LH, FUNC3_LW, FUNC3_LBU, FUNC3_LHU: ok = 1'b1;
            default:                                           ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic store_func3_ok(input logic [2:0] f3);
        logic ok;
        case (f3)
            FUNC3_SB, FUNC3_SH, FUNC3_SW: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_access_check.sv
// Combinational legality and alignment check for a load/store request.
module lsu_access_check
    import rv32_mem_pkg::*;
(
    input  logic [2:0] func3,
    input  logic [1:0] addr,
    input  logic       rd,
    input  logic       wr,
    output logic       illegal,
    output logic       misaligned
);

    // Legality: both directions at once is never a valid instruction.
    always_comb begin
        illegal = 1'b0;
        if (rd && wr) begin
            illegal = 1'b1;
        end else if (rd) begin
            illegal = !load_func3_ok(func3);
        end else if (wr) begin
            illegal = !store_func3_ok(func3);
        end else begin
            illegal = 1'b0;
        end
    end

    // Alignment from the access width encoded in func3[1:0].
    always_comb begin
        misaligned = 1'b0;
        case (func3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: issues the data-memory handshake, stalls
// the pipeline during an access and registers the MEM/WB result.
module mem_stage_lsu
    import rv32_mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        in_valid,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic [2:0]  in_func3,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_store_data,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_func3,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busywait,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] wb_data,
    output logic        exc_misaligned,
    output logic        exc_illegal,
    output logic        bus_error,
    output logic [31:0] exc_addr
);

    lsu_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mem_read;
    logic             r_mem_write;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [2:0]       r_mem_func3;
    logic             r_pend_reg_write;
    logic             r_wb_valid;
    logic [4:0]       r_wb_rd;
    logic             r_wb_reg_write;
    logic [31:0]      r_wb_data;
    logic             r_exc_misaligned;
    logic             r_exc_illegal;
    logic             r_bus_error;
    logic [31:0]      r_exc_addr;

    logic             w_mem_req;
    logic             w_illegal;
    logic             w_misaligned;
    logic             w_issue;
    logic             w_complete;
    logic             w_timeout;
    logic [CNT_W-1:0] w_cnt_next;

    lsu_access_check u_check (
        .func3      (in_func3),
        .addr       (in_alu_result[1:0]),
        .rd         (in_mem_read),
        .wr         (in_mem_write),
        .illegal    (w_illegal),
        .misaligned (w_misaligned)
    );

    assign w_mem_req  = in_valid & (in_mem_read | in_mem_write);
    assign w_issue    = w_mem_req & ~w_illegal & ~w_misaligned;
    assign w_cnt_next = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    // Counter >= 1 masks a busywait that memory raises only after seeing the request.
    assign w_complete = (r_cnt != {CNT_W{1'b0}}) & ~mem_busywait;
    assign w_timeout  = (w_cnt_next == CNT_W'(TIMEOUT_CYCLES));

    assign stall = ~Reset & ((r_state == ACCESS) | ((r_state != ACCESS) & w_issue));

    // LSU state machine, memory request registers and MEM/WB register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state          <= IDLE;
            r_cnt            <= {CNT_W{1'b0}};
            r_mem_read       <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_addr       <= 32'd0;
            r_mem_wdata      <= 32'd0;
            r_mem_func3      <= 3'd0;
            r_pend_reg_write <= 1'b0;
            r_wb_valid       <= 1'b0;
            r_wb_rd          <= 5'd0;
            r_wb_reg_write   <= 1'b0;
            r_wb_data        <= 32'd0;
            r_exc_misaligned <= 1'b0;
            r_exc_illegal    <= 1'b0;
            r_bus_error      <= 1'b0;
            r_exc_addr       <= 32'd0;
        end else begin
            r_exc_misaligned <= 1'b0;
            r_exc_illegal    <= 1'b0;
            r_bus_error      <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    r_state <= IDLE;
                    if (!in_valid) begin
                        r_wb_valid <= 1'b0;
                    end else if (!w_mem_req) begin
                        r_wb_valid     <= 1'b1;
                        r_wb_data      <= in_alu_result;
                        r_wb_rd        <= in_rd;
                        r_wb_reg_write <= in_reg_write;
                    end else if (w_illegal || w_misaligned) begin
                        r_exc_illegal    <= w_illegal;
                        r_exc_misaligned <= ~w_illegal;
                        r_exc_addr       <= in_alu_result;
                        r_wb_valid       <= 1'b1;
                        r_wb_rd          <= in_rd;
                        r_wb_reg_write   <= 1'b0;
                    end else begin
                        r_mem_read       <= in_mem_read;
                        r_mem_write      <= in_mem_write;
                        r_mem_addr       <= in_alu_result;
                        r_mem_wdata      <= in_store_data;
                        r_mem_func3      <= in_func3;
                        r_pend_reg_write <= in_reg_write & in_mem_read;
                        r_cnt            <= {CNT_W{1'b0}};
                        r_wb_valid       <= 1'b0;
                        r_wb_rd          <= in_rd;
                        r_state          <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_cnt <= w_cnt_next;
                    if (w_complete) begin
                        if (r_mem_read) begin
                            r_wb_data <= mem_rdata;
                        end else begin
                            r_wb_data <= r_wb_data;
                        end
                        r_wb_reg_write <= r_pend_reg_write;
                        r_wb_valid     <= 1'b1;
                        r_mem_read     <= 1'b0;
                        r_mem_write    <= 1'b0;
                        r_state        <= DONE;
                    end else if (w_timeout) begin
                        r_bus_error    <= 1'b1;
                        r_exc_addr     <= r_mem_addr;
                        r_wb_reg_write <= 1'b0;
                        r_wb_valid     <= 1'b1;
                        r_mem_read     <= 1'b0;
                        r_mem_write    <= 1'b0;
                        r_state        <= DONE;
                    end else begin
                        r_state <= ACCESS;
                    end
                end
                default: begin
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                    r_wb_valid  <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign mem_read       = r_mem_read;
    assign mem_write      = r_mem_write;
    assign mem_addr       = r_mem_addr;
    assign mem_wdata      = r_mem_wdata;
    assign mem_func3      = r_mem_func3;
    assign wb_valid       = r_wb_valid;
    assign wb_rd          = r_wb_rd;
    assign wb_reg_write   = r_wb_reg_write;
    assign wb_data        = r_wb_data;
    assign exc_misaligned = r_exc_misaligned;
    assign exc_illegal    = r_exc_illegal;
    assign bus_error      = r_bus_error;
    assign exc_addr       = r_exc_addr;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu with a small byte-addressed
// data memory model.
module tb_mem_stage_lsu;

    logic        Clock;
    logic        Reset;
    logic        in_valid;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [2:0]  in_func3;
    logic [31:0] in_alu_result;
    logic [31:0] in_store_data;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_func3;
    logic [31:0] mem_rdata;
    logic        mem_busywait;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        exc_misaligned;
    logic        exc_illegal;
    logic        bus_error;
    logic [31:0] exc_addr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:255];
    logic [7:0] a0, a1, a2, a3;

    mem_stage_lsu #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .in_valid       (in_valid),
        .in_mem_read    (in_mem_read),
        .in_mem_write   (in_mem_write),
        .in_func3       (in_func3),
        .in_alu_result  (in_alu_result),
        .in_store_data  (in_store_data),
        .in_rd          (in_rd),
        .in_reg_write   (in_reg_write),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_func3      (mem_func3),
        .mem_rdata      (mem_rdata),
        .mem_busywait   (mem_busywait),
        .stall          (stall),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_reg_write   (wb_reg_write),
        .wb_data        (wb_data),
        .exc_misaligned (exc_misaligned),
        .exc_illegal    (exc_illegal),
        .bus_error      (bus_error),
        .exc_addr       (exc_addr)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    assign a0 = mem_addr[7:0];
    assign a1 = mem_addr[7:0] + 8'd1;
    assign a2 = mem_addr[7:0] + 8'd2;
    assign a3 = mem_addr[7:0] + 8'd3;

    // Memory read port with the sign/zero extension done on the memory side.
    always_comb begin
        case (mem_func3)
            3'b000:  mem_rdata = {{24{mem[a0][7]}}, mem[a0]};
            3'b001:  mem_rdata = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
            3'b010:  mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
            3'b100:  mem_rdata = {24'd0, mem[a0]};
            3'b101:  mem_rdata = {16'd0, mem[a1], mem[a0]};
            default: mem_rdata = 32'd0;
        endcase
    end

    // Memory contents: preload while in reset, otherwise apply stores.
    always @(posedge Clock) begin
        if (Reset) begin
            mem[8'h10] <= 8'hEF;
            mem[8'h11] <= 8'hBE;
            mem[8'h12] <= 8'hAD;
            mem[8'h13] <= 8'hDE;
        end else if (mem_write) begin
            case (mem_func3)
                3'b000: mem[a0] <= mem_wdata[7:0];
                3'b001: begin
                    mem[a0] <= mem_wdata[7:0];
                    mem[a1] <= mem_wdata[15:8];
                end
                3'b010: begin
                    mem[a0] <= mem_wdata[7:0];
                    mem[a1] <= mem_wdata[15:8];
                    mem[a2] <= mem_wdata[23:16];
                    mem[a3] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rdst,
                         input logic rw);
        in_valid      = v;
        in_mem_read   = rd;
        in_mem_write  = wr;
        in_func3      = f3;
        in_alu_result = addr;
        in_store_data = sd;
        in_rd         = rdst;
        in_reg_write  = rw;
    endtask

    initial begin
        Reset        = 1'b1;
        mem_busywait = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        repeat (3) @(posedge Clock);
        #1;
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_exc_addr", exc_addr, 32'd0);
        Reset = 1'b0;

        // Non-memory pass-through.
        drive(1'b1, 1'b0, 1'b0, 3'd0, 32'h1234, 32'd0, 5'd5, 1'b1);
        #1 check("alu_stall_pre", 32'(stall), 32'd0);
        step();
        check("alu_wb_valid", 32'(wb_valid), 32'd1);
        check("alu_wb_data", wb_data, 32'h1234);
        check("alu_wb_rd", 32'(wb_rd), 32'd5);
        check("alu_wb_rw", 32'(wb_reg_write), 32'd1);
        check("alu_stall", 32'(stall), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        step();
        check("alu_wb_valid_drop", 32'(wb_valid), 32'd0);

        // LW at 0x10.
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 5'd7, 1'b1);
        #1 check("lw_stall_pre", 32'(stall), 32'd1);
        check("lw_rd_pre", 32'(mem_read), 32'd0);
        step();
        check("lw_rd_e0", 32'(mem_read), 32'd1);
        check("lw_addr_e0", mem_addr, 32'h10);
        check("lw_f3_e0", 32'(mem_func3), 32'd2);
        check("lw_stall_e0", 32'(stall), 32'd1);
        check("lw_wbv_e0", 32'(wb_valid), 32'd0);
        step();
        check("lw_rd_e1", 32'(mem_read), 32'd1);
        check("lw_stall_e1", 32'(stall), 32'd1);
        check("lw_wbv_e1", 32'(wb_valid), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        step();
        check("lw_rd_e2", 32'(mem_read), 32'd0);
        check("lw_stall_e2", 32'(stall), 32'd0);
        check("lw_wbv_e2", 32'(wb_valid), 32'd1);
        check("lw_data", wb_data, 32'hDEADBEEF);
        check("lw_wb_rd", 32'(wb_rd), 32'd7);
        check("lw_wb_rw", 32'(wb_reg_write), 32'd1);
        step();
        check("lw_done_wbv", 32'(wb_valid), 32'd0);

        // SB at 0x13, then LBU at 0x13 accepted straight from DONE.
        drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h13, 32'h123456AB, 5'd9, 1'b1);
        step();
        check("sb_wr_e0", 32'(mem_write), 32'd1);
        check("sb_rd_e0", 32'(mem_read), 32'd0);
        check("sb_wdata", mem_wdata, 32'h123456AB);
        step();
        check("sb_wr_e1", 32'(mem_write), 32'd1);
        drive(1'b1, 1'b1, 1'b0, 3'b100, 32'h13, 32'd0, 5'd10, 1'b1);
        step();
        check("sb_wr_e2", 32'(mem_write), 32'd0);
        check("sb_wbv", 32'(wb_valid), 32'd1);
        check("sb_wb_rw", 32'(wb_reg_write), 32'd0);
        check("sb_wb_data_kept", wb_data, 32'hDEADBEEF);
        step();
        check("lbu_rd_e0", 32'(mem_read), 32'd1);
        check("lbu_wbv_e0", 32'(wb_valid), 32'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        step();
        check("lbu_wbv", 32'(wb_valid), 32'd1);
        check("lbu_data", wb_data, 32'h000000AB);
        check("lbu_wb_rd", 32'(wb_rd), 32'd10);
        step();

        // Misaligned LW at 0x12 and SH at 0x21.
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h12, 32'd0, 5'd3, 1'b1);
        #1 check("lw_mis_stall", 32'(stall), 32'd0);
        step();
        check("lw_mis_exc", 32'(exc_misaligned), 32'd1);
        check("lw_mis_ill", 32'(exc_illegal), 32'd0);
        check("lw_mis_addr", exc_addr, 32'h12);
        check("lw_mis_rd", 32'(mem_read), 32'd0);
        check("lw_mis_wbv", 32'(wb_valid), 32'd1);
        check("lw_mis_wb_rw", 32'(wb_reg_write), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h21, 32'h5555, 5'd0, 1'b0);
        step();
        check("sh_mis_exc", 32'(exc_misaligned), 32'd1);
        check("sh_mis_addr", exc_addr, 32'h21);
        check("sh_mis_wr", 32'(mem_write), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        step();
        check("mis_pulse_end", 32'(exc_misaligned), 32'd0);
        check("mis_wbv_end", 32'(wb_valid), 32'd0);

        // Illegal func3, and read+write together (also misaligned: illegal wins).
        drive(1'b1, 1'b1, 1'b0, 3'b011, 32'h40, 32'd0, 5'd4, 1'b1);
        step();
        check("ill_exc", 32'(exc_illegal), 32'd1);
        check("ill_mis", 32'(exc_misaligned), 32'd0);
        check("ill_addr", exc_addr, 32'h40);
        check("ill_rd", 32'(mem_read), 32'd0);
        check("ill_wb_rw", 32'(wb_reg_write), 32'd0);
        drive(1'b1, 1'b1, 1'b1, 3'b010, 32'h46, 32'd0, 5'd4, 1'b1);
        step();
        check("rw_ill_exc", 32'(exc_illegal), 32'd1);
        check("rw_ill_mis", 32'(exc_misaligned), 32'd0);
        check("rw_ill_addr", exc_addr, 32'h46);
        check("rw_ill_wr", 32'(mem_write), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        step();
        check("ill_pulse_end", 32'(exc_illegal), 32'd0);

        // Timeout with busywait held high.
        mem_busywait = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h20, 32'd0, 5'd6, 1'b1);
        step();
        check("to_rd_e0", 32'(mem_read), 32'd1);
        for (int i = 0; i < 15; i++) begin
            step();
            check("to_no_err", 32'(bus_error), 32'd0);
            check("to_stall", 32'(stall), 32'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        step();
        check("to_bus_error", 32'(bus_error), 32'd1);
        check("to_rd_drop", 32'(mem_read), 32'd0);
        check("to_wbv", 32'(wb_valid), 32'd1);
        check("to_wb_rw", 32'(wb_reg_write), 32'd0);
        check("to_stall_done", 32'(stall), 32'd0);
        step();
        check("to_err_end", 32'(bus_error), 32'd0);
        check("to_wbv_end", 32'(wb_valid), 32'd0);
        check("to_idle_stall", 32'(stall), 32'd0);
        mem_busywait = 1'b0;

        // Reset in the second ACCESS cycle, then a normal LW.
        drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 5'd8, 1'b1);
        step();
        step();
        check("rs_rd_before", 32'(mem_read), 32'd1);
        Reset = 1'b1;
        #1;
        check("rs_mem_read", 32'(mem_read), 32'd0);
        check("rs_stall", 32'(stall), 32'd0);
        check("rs_mem_addr", mem_addr, 32'd0);
        check("rs_mem_func3", 32'(mem_func3), 32'd0);
        check("rs_wb_data", wb_data, 32'd0);
        check("rs_wb_rd", 32'(wb_rd), 32'd0);
        step();
        Reset = 1'b0;
        #1 check("rs_lw_stall_pre", 32'(stall), 32'd1);
        step();
        check("rs_lw_rd_e0", 32'(mem_read), 32'd1);
        step();
        drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        step();
        check("rs_lw_wbv", 32'(wb_valid), 32'd1);
        check("rs_lw_data", wb_data, 32'hDEADBEEF);
        check("rs_lw_rd_drop", 32'(mem_read), 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit of the RV32IM pipeline, between the EX/MEM pipeline register and the data memory.
- For load/store instructions it:
  - checks alignment and func3 legality,
  - drives the memory Read/Write/Address/Func3 handshake,
  - stalls the pipeline while memory is busy,
  - registers the result into MEM/WB.
- Non-memory instructions pass straight through to MEM/WB with 1-cycle latency.

Parameters:
- TIMEOUT_CYCLES, 16, maximum cycles in ACCESS before bus_error is raised.
- CNT_W, 5, width of the access cycle counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- Clock  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  EX/MEM holds a valid instruction.
- in_mem_read  in  1  instruction is a load.
- in_mem_write  in  1  instruction is a store.
- in_func3  in  3  RV32 load/store width code.
- in_alu_result  in  32  effective address, or ALU result for non-memory instructions.
- in_store_data  in  32  rs2 value, unshifted.
- in_rd  in  5  destination register.
- in_reg_write  in  1  instruction writes rd.
- mem_read  out  1  to data memory Read.
- mem_write  out  1  to data memory Write.
- mem_addr  out  32  to data memory Address (byte address).
- mem_wdata  out  32  to data memory Write_data.
- mem_func3  out  3  to data memory Func3.
- mem_rdata  in  32  from data memory Read_data, already sign/zero-extended.
- mem_busywait  in  1  from data memory.
- stall  out  1  freeze IF/ID/EX and EX/MEM.
- wb_valid  out  1  MEM/WB holds a valid instruction.
- wb_rd  out  5  registered destination register.
- wb_reg_write  out  1  registered write enable, forced 0 on exception.
- wb_data  out  32  load data or ALU result.
- exc_misaligned  out  1  1-cycle pulse: misaligned access.
- exc_illegal  out  1  1-cycle pulse: illegal func3 for a load/store.
- bus_error  out  1  1-cycle pulse: memory timeout.
- exc_addr  out  32  faulting address, valid while any exception pulse is high.

Behaviour:
- Reset (asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including mem_addr, mem_wdata, mem_func3, wb_data and exc_addr.
  - The counter is cleared.
  - Reset in the middle of ACCESS abandons the access and drops mem_read/mem_write immediately. A store may or may not have committed; there is no replay.
- mem_req = in_valid & (in_mem_read | in_mem_write). If both read and write are set, the instruction is treated as illegal.
- Legality:
  - Loads accept func3 in {000, 001, 010, 100, 101}.
  - Stores accept func3 in {000, 001, 010}.
  - Any other func3 raises exc_illegal.
- Alignment:
  - Halfword (x01) requires addr[0]=0.
  - Word (010) requires addr[1:0]=00.
  - Byte accesses are always aligned.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If !in_valid: wb_valid<=0.
  - If in_valid & !mem_req: register the pass-through (wb_data<=in_alu_result, wb_rd, wb_reg_write) and set wb_valid<=1. stall=0.
  - If mem_req is illegal or misaligned: pulse the matching exception with exc_addr=in_alu_result; set wb_valid<=1 and wb_reg_write<=0; stall=0. No memory access is issued.
  - If mem_req is legal: register mem_read/mem_write, mem_addr, mem_wdata, mem_func3; clear the counter; set wb_valid<=0; go to ACCESS. stall=1 combinationally in this cycle.
- ACCESS:
  - The counter increments every cycle and stall=1.
  - Completion requires counter>=1 and mem_busywait=0 sampled at the rising edge. This guards against busywait rising combinationally after the request is issued.
  - On completion:
    - Capture wb_data<=mem_rdata for a load; for a store wb_data is unchanged and wb_reg_write<=0.
    - Set wb_valid<=1.
    - Drop mem_read/mem_write.
    - Go to DONE.
  - If the counter reaches TIMEOUT_CYCLES: pulse bus_error, drop the requests, set wb_valid<=1 with wb_reg_write=0, go to DONE.
- DONE:
  - Lasts 1 cycle and stall=0, so EX/MEM advances.
  - wb_valid<=0 unless the next instruction is accepted per the IDLE rules in the same cycle. DONE evaluates its input exactly as IDLE does.
- Request timing:
  - mem_addr, mem_wdata and mem_func3 are held stable for the whole of ACCESS.
  - mem_read and mem_write are never both 1.
- Load latency:
  - Request issued at edge E0.
  - Memory completes at edge E1.
  - The LSU samples busywait=0 at edge E2, so wb_valid is high after E2.
  - stall is high from before E0 through E2, i.e. 3 cycles.
- Stores use identical timing.
- Exceptions have priority over memory access. Illegal has priority over misaligned if both apply.

Decomposition:
- Shared package rv32_mem_pkg holds:
  - FUNC3_LB/LH/LW/LBU/LHU/SB/SH/SW constants,
  - the lsu_state_t encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2).
- Sub-module lsu_access_check: combinational legality and alignment check, with inputs func3, addr[1:0], rd, wr and outputs illegal, misaligned.
- The FSM and the MEM/WB register stay in the top level.

Test Plan:
- Non-memory op, in_alu_result=0x1234, rd=5 → wb_valid=1, wb_data=0x1234, wb_rd=5 after 1 edge; stall never asserted.
- LW at 0x10 with memory word 0xDEADBEEF → mem_read high for exactly 2 edges; stall high 3 cycles; wb_data=0xDEADBEEF.
- SB at 0x13 with data 0xAB, then LBU at 0x13 → the load returns 0x000000AB; for the SB, wb_reg_write=0.
- LW at 0x12 → exc_misaligned pulses once with exc_addr=0x12; mem_read never asserts; wb_reg_write=0. Also: SH at 0x21 → exc_misaligned.
- Load with func3=011 → exc_illegal pulse, no memory access. Separately, hold mem_busywait=1 → bus_error after 16 cycles in ACCESS, then the FSM returns to IDLE.
- Assert Reset in the 2nd ACCESS cycle → all outputs 0 immediately; the next LW after reset completes normally.
